// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX stage and its forwarding logic.
// Holds the ALU op encoding, operand-select enums, default widths and the
// packed payload carried in the ID/EX pipeline register.
package pipe_pkg;

  localparam int PIPE_XLEN   = 32;
  localparam int PIPE_REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_PASSB = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  typedef enum logic {
    A_SEL_RS1 = 1'b0,
    A_SEL_PC  = 1'b1
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  // Payload widths follow the package defaults; the stage parameters must
  // stay at these values for the struct to line up with the ports.
  typedef struct packed {
    logic                   valid;
    logic                   rd_wren;
    logic                   is_load;
    logic [3:0]             alu_op;
    a_sel_e                 a_sel;
    b_sel_e                 b_sel;
    logic [PIPE_XLEN-1:0]   pc;
    logic [PIPE_XLEN-1:0]   rs1_data;
    logic [PIPE_XLEN-1:0]   rs2_data;
    logic [PIPE_XLEN-1:0]   imm;
    logic [PIPE_REG_AW-1:0] rs1_addr;
    logic [PIPE_REG_AW-1:0] rs2_addr;
    logic [PIPE_REG_AW-1:0] rd_addr;
  } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand forwarding for one source register.
// Ports:
//   src_addr_i / src_data_i    : source index and value held in ID/EX
//   mem_rd_addr_i/_wren_i/_data_i : EX/MEM producer
//   wb_rd_addr_i/_wren_i/_data_i  : MEM/WB producer
//   fwd_data_o                 : resolved operand value
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int XLEN   = PIPE_XLEN,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [XLEN-1:0]   src_data_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   fwd_data_o
);

  // MEM is younger than WB, so it is checked first. x0 is hardwired zero
  // and never forwarded even if a producer claims to write it.
  always_comb begin
    fwd_data_o = src_data_i;
    if (mem_rd_wren_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == src_addr_i)) begin
      fwd_data_o = mem_data_i;
    end else if (wb_rd_wren_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == src_addr_i)) begin
      fwd_data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clk_i, rst_ni           : clock, async active-low reset
//   flush_i, stall_i        : kill entering instruction / hold EX contents
//   id_*                    : decoded instruction from ID
//   mem_*, wb_*             : EX/MEM and MEM/WB writeback producers
//   operand_a_o/_b_o, alu_op_o, store_data_o : to ALU / store path
//   ex_*                    : registered EX control and identity
//   stall_o                 : load-use stall request back to IF/ID
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = PIPE_XLEN,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic              id_a_sel_i,
  input  logic              id_b_sel_i,
  input  logic              id_rd_wren_i,
  input  logic              id_is_load_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   operand_a_o,
  output logic [XLEN-1:0]   operand_b_o,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_rd_wren_o,
  output logic              ex_is_load_o,
  output logic              ex_valid_o,
  output logic              stall_o
);

  id_ex_t            r_q;
  logic              w_hazard;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;

  // Both source fields are compared regardless of operand select; a
  // spurious stall on an unused field costs one cycle but keeps this simple.
  assign w_hazard = r_q.valid && r_q.is_load && (r_q.rd_addr != '0) && id_valid_i &&
                    ((id_rs1_addr_i == r_q.rd_addr) || (id_rs2_addr_i == r_q.rd_addr));

  assign stall_o = w_hazard && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q        <= '0;
      r_q.alu_op <= ALU_ADD;
    end else if (flush_i) begin
      r_q.valid   <= 1'b0;
      r_q.rd_wren <= 1'b0;
      r_q.is_load <= 1'b0;
    end else if (stall_i) begin
      r_q <= r_q;
    end else if (w_hazard) begin
      // ID is held upstream by stall_o, so only the control bits need killing.
      r_q.valid   <= 1'b0;
      r_q.rd_wren <= 1'b0;
      r_q.is_load <= 1'b0;
    end else begin
      r_q.valid    <= id_valid_i;
      r_q.rd_wren  <= id_rd_wren_i && id_valid_i;
      r_q.is_load  <= id_is_load_i && id_valid_i;
      r_q.alu_op   <= id_alu_op_i;
      r_q.a_sel    <= a_sel_e'(id_a_sel_i);
      r_q.b_sel    <= b_sel_e'(id_b_sel_i);
      r_q.pc       <= id_pc_i;
      r_q.rs1_data <= id_rs1_data_i;
      r_q.rs2_data <= id_rs2_data_i;
      r_q.imm      <= id_imm_i;
      r_q.rs1_addr <= id_rs1_addr_i;
      r_q.rs2_addr <= id_rs2_addr_i;
      r_q.rd_addr  <= id_rd_addr_i;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_addr_i    (r_q.rs1_addr),
    .src_data_i    (r_q.rs1_data),
    .mem_rd_addr_i (mem_rd_addr_i),
    .mem_rd_wren_i (mem_rd_wren_i),
    .mem_data_i    (mem_data_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_rd_wren_i  (wb_rd_wren_i),
    .wb_data_i     (wb_data_i),
    .fwd_data_o    (w_fwd_rs1)
  );

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_addr_i    (r_q.rs2_addr),
    .src_data_i    (r_q.rs2_data),
    .mem_rd_addr_i (mem_rd_addr_i),
    .mem_rd_wren_i (mem_rd_wren_i),
    .mem_data_i    (mem_data_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_rd_wren_i  (wb_rd_wren_i),
    .wb_data_i     (wb_data_i),
    .fwd_data_o    (w_fwd_rs2)
  );

  assign operand_a_o  = (r_q.a_sel == A_SEL_PC)  ? r_q.pc  : w_fwd_rs1;
  assign operand_b_o  = (r_q.b_sel == B_SEL_IMM) ? r_q.imm : w_fwd_rs2;
  assign store_data_o = w_fwd_rs2;
  assign alu_op_o     = r_q.alu_op;
  assign ex_pc_o      = r_q.pc;
  assign ex_rd_addr_o = r_q.rd_addr;
  assign ex_rd_wren_o = r_q.rd_wren;
  assign ex_is_load_o = r_q.is_load;
  assign ex_valid_o   = r_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, stall_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [3:0]  id_alu_op_i;
  logic        id_a_sel_i, id_b_sel_i, id_rd_wren_i, id_is_load_i;
  logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
  logic        mem_rd_wren_i, wb_rd_wren_i;
  logic [31:0] mem_data_i, wb_data_i;
  logic [31:0] operand_a_o, operand_b_o, store_data_o, ex_pc_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wren_o, ex_is_load_o, ex_valid_o, stall_o;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .stall_i(stall_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_alu_op_i(id_alu_op_i), .id_a_sel_i(id_a_sel_i), .id_b_sel_i(id_b_sel_i),
    .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i), .mem_data_i(mem_data_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_data_i(wb_data_i),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .alu_op_o(alu_op_o),
    .store_data_o(store_data_o), .ex_pc_o(ex_pc_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_wren_o(ex_rd_wren_o), .ex_is_load_o(ex_is_load_o), .ex_valid_o(ex_valid_o),
    .stall_o(stall_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [3:0]  op;
    logic        asel, bsel, wren, load;
    logic [4:0]  ma, wa;
    logic        mw, ww;
    logic [31:0] md, wd;
    logic        chk_ops;
    logic [31:0] ea, eb, es;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] pc,
                              input logic [4:0] rs1a, input logic [31:0] rs1d,
                              input logic [4:0] rs2a, input logic [31:0] rs2d,
                              input logic [4:0] rda, input logic [31:0] imm,
                              input logic [3:0] op, input logic asel, input logic bsel,
                              input logic wren, input logic load);
    vec_t r;
    r.valid = v; r.pc = pc; r.rs1a = rs1a; r.rs1d = rs1d; r.rs2a = rs2a; r.rs2d = rs2d;
    r.rda = rda; r.imm = imm; r.op = op; r.asel = asel; r.bsel = bsel;
    r.wren = wren; r.load = load;
    r.ma = 5'd0; r.mw = 1'b0; r.md = 32'h0; r.wa = 5'd0; r.ww = 1'b0; r.wd = 32'h0;
    r.chk_ops = 1'b1; r.ea = 32'h0; r.eb = 32'h0; r.es = 32'h0;
    return r;
  endfunction

  task automatic apply_id(input vec_t v);
    id_valid_i = v.valid; id_pc_i = v.pc; id_rs1_addr_i = v.rs1a; id_rs1_data_i = v.rs1d;
    id_rs2_addr_i = v.rs2a; id_rs2_data_i = v.rs2d; id_rd_addr_i = v.rda; id_imm_i = v.imm;
    id_alu_op_i = v.op; id_a_sel_i = v.asel; id_b_sel_i = v.bsel;
    id_rd_wren_i = v.wren; id_is_load_i = v.load;
  endtask

  task automatic apply_fwd(input vec_t v);
    mem_rd_addr_i = v.ma; mem_rd_wren_i = v.mw; mem_data_i = v.md;
    wb_rd_addr_i = v.wa; wb_rd_wren_i = v.ww; wb_data_i = v.wd;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_opa"}, operand_a_o, 32'h0);
    chk({tag, "_opb"}, operand_b_o, 32'h0);
    chk({tag, "_op"}, 32'(alu_op_o), 32'h0);
    chk({tag, "_st"}, store_data_o, 32'h0);
    chk({tag, "_pc"}, ex_pc_o, 32'h0);
    chk({tag, "_rd"}, 32'(ex_rd_addr_o), 32'h0);
    chk({tag, "_wren"}, 32'(ex_rd_wren_o), 32'h0);
    chk({tag, "_load"}, 32'(ex_is_load_o), 32'h0);
    chk({tag, "_valid"}, 32'(ex_valid_o), 32'h0);
    chk({tag, "_stall"}, 32'(stall_o), 32'h0);
  endtask

  vec_t idle, v, lw, dep;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 0);

    // ADD, no forwarding
    vecs[0] = mk(1, 32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 4'h0, 0, 0, 1, 0);
    vecs[0].ea = 32'd5; vecs[0].eb = 32'd7; vecs[0].es = 32'd7;
    // XOR, MEM forward onto rs1
    vecs[1] = mk(1, 32'h14, 5'd3, 32'd1, 5'd4, 32'd2, 5'd5, 32'h0, 4'h4, 0, 0, 1, 0);
    vecs[1].ma = 5'd3; vecs[1].mw = 1; vecs[1].md = 32'h55;
    vecs[1].ea = 32'h55; vecs[1].eb = 32'd2; vecs[1].es = 32'd2;
    // OR, WB forward onto rs2 and store data
    vecs[2] = mk(1, 32'h18, 5'd5, 32'd9, 5'd6, 32'hA, 5'd7, 32'h0, 4'h6, 0, 0, 1, 0);
    vecs[2].wa = 5'd6; vecs[2].ww = 1; vecs[2].wd = 32'h66;
    vecs[2].ea = 32'd9; vecs[2].eb = 32'h66; vecs[2].es = 32'h66;
    // SLL on x0 sources: producers claiming x0 must not forward
    vecs[3] = mk(1, 32'h1C, 5'd0, 32'h11, 5'd0, 32'h22, 5'd8, 32'h0, 4'h1, 0, 0, 1, 0);
    vecs[3].ma = 5'd0; vecs[3].mw = 1; vecs[3].md = 32'hDEAD;
    vecs[3].wa = 5'd0; vecs[3].ww = 1; vecs[3].wd = 32'hBEEF;
    vecs[3].ea = 32'h11; vecs[3].eb = 32'h22; vecs[3].es = 32'h22;
    // invalid ID slot: wren/load must be gated off
    vecs[4] = mk(0, 32'h20, 5'd8, 32'h88, 5'd9, 32'h99, 5'd10, 32'h0, 4'h7, 0, 0, 1, 1);
    vecs[4].chk_ops = 0;
    // ADDI with imm select; store data still sees WB forward of rs2
    vecs[5] = mk(1, 32'h24, 5'd2, 32'h3, 5'd7, 32'h4, 5'd11, 32'h123, 4'h0, 0, 1, 1, 0);
    vecs[5].wa = 5'd7; vecs[5].ww = 1; vecs[5].wd = 32'h77;
    vecs[5].ea = 32'h3; vecs[5].eb = 32'h123; vecs[5].es = 32'h77;

    // Reset
    rst_ni = 1'b0; flush_i = 0; stall_i = 0;
    apply_id(idle); apply_fwd(idle);
    #3;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Table-driven capture
    foreach (vecs[i]) begin
      apply_id(vecs[i]); apply_fwd(vecs[i]);
      step();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d_wren", i), 32'(ex_rd_wren_o), 32'(vecs[i].wren & vecs[i].valid));
      chk($sformatf("v%0d_load", i), 32'(ex_is_load_o), 32'(vecs[i].load & vecs[i].valid));
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'h0);
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d_opa", i), operand_a_o, vecs[i].ea);
        chk($sformatf("v%0d_opb", i), operand_b_o, vecs[i].eb);
        chk($sformatf("v%0d_st", i), store_data_o, vecs[i].es);
        chk($sformatf("v%0d_op", i), 32'(alu_op_o), 32'(vecs[i].op));
        chk($sformatf("v%0d_pc", i), ex_pc_o, vecs[i].pc);
        chk($sformatf("v%0d_rd", i), 32'(ex_rd_addr_o), 32'(vecs[i].rda));
      end
    end
    apply_fwd(idle);

    // MEM vs WB priority on rs1 = x3
    v = mk(1, 32'h200, 5'd3, 32'h33, 5'd4, 32'h44, 5'd5, 32'h0, 4'h0, 0, 0, 1, 0);
    apply_id(v);
    step();
    apply_id(idle);
    mem_rd_addr_i = 5'd3; mem_rd_wren_i = 1; mem_data_i = 32'hAA;
    wb_rd_addr_i = 5'd3; wb_rd_wren_i = 1; wb_data_i = 32'hBB;
    #1 chk("prio_mem", operand_a_o, 32'hAA);
    mem_rd_wren_i = 0;
    #1 chk("prio_wb", operand_a_o, 32'hBB);
    mem_rd_wren_i = 1; mem_rd_addr_i = 5'd0; wb_rd_addr_i = 5'd0;
    #1 chk("prio_x0", operand_a_o, 32'h33);
    apply_fwd(idle);

    // Load-use: LW x4 then consumer of x4 via rs2
    lw = mk(1, 32'h300, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd4, 32'h8, 4'h0, 0, 1, 1, 1);
    dep = mk(1, 32'h304, 5'd2, 32'h20, 5'd4, 32'h44, 5'd6, 32'h0, 4'h8, 0, 0, 1, 0);
    apply_id(lw);
    step();
    apply_id(dep);
    #1 chk("lu_stall", 32'(stall_o), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid_o), 32'h0);
    chk("lu_bubble_wren", 32'(ex_rd_wren_o), 32'h0);
    chk("lu_stall_clear", 32'(stall_o), 32'h0);
    step();
    chk("lu_dep_valid", 32'(ex_valid_o), 32'h1);
    chk("lu_dep_rd", 32'(ex_rd_addr_o), 32'd6);
    chk("lu_dep_opb", operand_b_o, 32'h44);
    chk("lu_dep_op", 32'(alu_op_o), 32'h8);

    // stall_i hold with WB forward during the hold
    v = mk(1, 32'h40, 5'd1, 32'h50, 5'd2, 32'h20, 5'd6, 32'h0, 4'h8, 0, 0, 1, 0);
    apply_id(v);
    step();
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      v = mk(1, 32'h80 + k, 5'd10 + 5'(k), 32'h1000 + k, 5'd20, 32'h2000 + k,
             5'd12, 32'h5 + k, 4'(k), 1, 1, 1, 0);
      apply_id(v);
      if (k == 1) begin
        wb_rd_addr_i = 5'd1; wb_rd_wren_i = 1; wb_data_i = 32'h10;
      end
      step();
      chk($sformatf("hold%0d_opa", k), operand_a_o, (k >= 1) ? 32'h10 : 32'h50);
      chk($sformatf("hold%0d_opb", k), operand_b_o, 32'h20);
      chk($sformatf("hold%0d_op", k), 32'(alu_op_o), 32'h8);
      chk($sformatf("hold%0d_pc", k), ex_pc_o, 32'h40);
      chk($sformatf("hold%0d_valid", k), 32'(ex_valid_o), 32'h1);
    end
    stall_i = 0;
    apply_fwd(idle);

    // Hazard together with stall_i: hold wins, stall_o still raised
    lw = mk(1, 32'h400, 5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 32'h0, 4'h0, 0, 1, 1, 1);
    dep = mk(1, 32'h404, 5'd5, 32'h0, 5'd9, 32'h0, 5'd7, 32'h0, 4'h0, 0, 0, 1, 0);
    apply_id(lw);
    step();
    apply_id(dep);
    stall_i = 1;
    #1 chk("hs_stall", 32'(stall_o), 32'h1);
    step();
    chk("hs_hold_valid", 32'(ex_valid_o), 32'h1);
    chk("hs_hold_load", 32'(ex_is_load_o), 32'h1);
    chk("hs_hold_rd", 32'(ex_rd_addr_o), 32'd5);
    stall_i = 0;

    // Flush with a pending hazard: flush wins, stall_o low, bubble follows
    flush_i = 1;
    #1 chk("fl_stall", 32'(stall_o), 32'h0);
    step();
    chk("fl_valid", 32'(ex_valid_o), 32'h0);
    chk("fl_wren", 32'(ex_rd_wren_o), 32'h0);
    chk("fl_load", 32'(ex_is_load_o), 32'h0);
    flush_i = 0;

    // PC / immediate select; forward on rs1 must not affect operand_a
    v = mk(1, 32'h100, 5'd9, 32'h99, 5'd0, 32'h0, 5'd10, 32'h2000, 4'h0, 1, 1, 1, 0);
    apply_id(v);
    step();
    apply_id(idle);
    chk("pc_opa", operand_a_o, 32'h100);
    chk("pc_opb", operand_b_o, 32'h2000);
    mem_rd_addr_i = 5'd9; mem_rd_wren_i = 1; mem_data_i = 32'hFFFF;
    #1 chk("pc_opa_fwd", operand_a_o, 32'h100);
    apply_fwd(idle);

    // Asynchronous reset asserted mid-cycle
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("areset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand forwarding; sits directly upstream of the ALU and drives its operand_a, operand_b and alu_op inputs.
- Captures decoded fields each cycle and inserts bubbles on flush or load-use hazard.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Raises a one-cycle stall request on a load-use dependency.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill the instruction entering EX (branch mispredict)
- stall_i  in  1  hold the EX contents (downstream memory busy)
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  REG_AW  register indices
- id_alu_op_i  in  4  ALU code: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 pass-B, D SRA
- id_a_sel_i  in  1  0=rs1, 1=PC
- id_b_sel_i  in  1  0=rs2, 1=imm
- id_rd_wren_i, id_is_load_i  in  1  writeback / load flags
- mem_rd_addr_i  in  REG_AW  EX/MEM destination
- mem_rd_wren_i  in  1  EX/MEM will write
- mem_data_i  in  XLEN  EX/MEM ALU result
- wb_rd_addr_i, wb_rd_wren_i, wb_data_i  in  REG_AW/1/XLEN  MEM/WB writeback
- operand_a_o, operand_b_o  out  XLEN  to ALU
- alu_op_o  out  4  to ALU
- store_data_o  out  XLEN  forwarded rs2 for stores
- ex_pc_o  out  XLEN
- ex_rd_addr_o  out  REG_AW
- ex_rd_wren_o, ex_is_load_o, ex_valid_o  out  1
- stall_o  out  1  load-use stall request to IF/ID

Behaviour:
- Reset (async, rst_ni=0):
  - All registered fields are 0: valid=0, rd_wren=0, is_load=0, alu_op=0 (ADD).
  - Outputs are therefore 0 and stall_o=0.
- Load-use hazard (combinational):
  - hazard = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
  - Checks both source fields regardless of sel.
  - stall_o = hazard & ~flush_i.
- Register update at the clock edge, in priority order:
  1. flush_i: bubble. valid, rd_wren and is_load go to 0; other fields are don't-care but are held.
  2. stall_i: hold all fields, including the captured rs data. Forwarding still applies to the held values each cycle.
  3. hazard: bubble into EX. The upstream stage holds ID because of stall_o, so the same instruction re-presents next cycle.
  4. Otherwise: capture all id_* fields. valid=id_valid_i; rd_wren and is_load are gated by id_valid_i.
- Forwarding (combinational on registered rs1/rs2 fields):
  - fwd_rs1 = mem_data_i if mem_rd_wren_i & mem_rd_addr_i!=0 & match.
  - Else wb_data_i if wb_rd_wren_i & wb_rd_addr_i!=0 & match.
  - Else the registered rs1_data. rs2 is resolved the same way.
  - MEM beats WB when both match (youngest wins). x0 is never forwarded.
- Output muxes:
  - operand_a_o = a_sel ? ex_pc : fwd_rs1.
  - operand_b_o = b_sel ? ex_imm : fwd_rs2.
  - store_data_o = fwd_rs2.
  - alu_op_o is passed through unchanged from the register.
  - Outputs are purely combinational from the register and forward inputs, with zero added latency.
- Latency: an instruction is visible on the outputs one cycle after capture.
- A bubble shows valid=0 and rd_wren=0. Its operands are don't-care, but the bench checks that a bubble never writes.
- Hazard and flush in the same cycle: flush wins and stall_o=0.
- Hazard and stall_i in the same cycle: hold wins. stall_o still reflects the hazard.

Decomposition:
- Shared package pipe_pkg:
  - ALU op code constants 4'h0..4'hD matching the ALU's input encoding.
  - a_sel/b_sel enums.
  - XLEN/REG_AW defaults.
  - packed struct id_ex_t for the registered payload.
- One sub-module fwd_unit: combinational forward select, instantiated twice (rs1, rs2).
  - Inputs: src_addr, src_data, mem and wb triples.
  - Output: forwarded data.

Test Plan:
- Reset then capture: assert rst_ni=0 mid-cycle and check all outputs are 0 asynchronously. Release, present ADD with rs1=5, rs2=7 data and a_sel=0, b_sel=0 → next cycle operand_a_o=5, operand_b_o=7, alu_op_o=0, ex_valid_o=1.
- MEM vs WB priority: EX holds rs1=x3; drive mem_rd=3 with data 0xAA and wb_rd=3 with data 0xBB → operand_a_o=0xAA. Drop mem_rd_wren → 0xBB. Set both rd=0 → the registered value.
- Load-use: EX holds LW rd=x4; ID reads rs2=x4 → stall_o=1 that cycle. Next cycle ex_valid_o=0 and rd_wren=0. The following cycle the dependent instruction is captured with stall_o=0.
- Flush priority: flush_i=1 together with a hazard and a valid ID instruction → stall_o=0 and the next cycle is a bubble.
- stall_i hold: capture SUB rs1=x1, then assert stall_i for 3 cycles while changing id_* inputs → outputs are unchanged. Drive wb_rd=1 with data 0x10 during the hold → operand_a_o=0x10.
- Immediate/PC select: AUIPC-like, a_sel=1, b_sel=1, pc=0x100, imm=0x2000 → operand_a_o=0x100, operand_b_o=0x2000. A matching forward on rs1 does not change operand_a_o.
